// File: rtl/mux_4bit_rr_feeder_pkg.sv
// Shared encodings and defaults for the round-robin mux feeder.
package mux_4bit_rr_feeder_pkg;

  // Presentation FSM: IDLE shows nothing, DWELL holds a word while the counter runs down
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_e;

  // Mux select encoding, also used to remember which channel was granted last
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/mux_4bit_rr_feeder_rr_arbiter_2.sv
// Two-requester round-robin arbiter, purely combinational.
// req[0] is channel A, req[1] is channel B; grant is one-hot or zero.
module rr_arbiter_2
  import mux_4bit_rr_feeder_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the channel not granted last time wins
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == SEL_B) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mux_4bit_rr_feeder.sv
// Upstream feeder for a 2-to-1 mux: takes words from two valid/ready sources,
// arbitrates round-robin and presents each accepted word for DWELL cycles.
module mux_4bit_rr_feeder
  import mux_4bit_rr_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             s,
  output logic             out_valid
);

  // Counter reload; with DWELL limited to 1..255 this always fits in 8 bits
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] aOut_q, aOut_d;
  logic [WIDTH-1:0] bOut_q, bOut_d;
  logic             sel_q, sel_d;
  logic             outValid_q, outValid_d;

  logic             acceptOpen;
  logic [1:0]       grant;
  logic             xferA;
  logic             xferB;

  // The accept window is open when idle or on the last dwell cycle, never during reset
  always_comb begin
    acceptOpen = 1'b0;
    if (!rst) begin
      acceptOpen = (state_q == ST_IDLE) ||
                   ((state_q == ST_DWELL) && (cnt_q == '0));
    end
  end

  rr_arbiter_2 uArb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_q),
    .enable     (acceptOpen),
    .grant      (grant)
  );

  // A grant only exists when the channel is valid, so a grant is a transfer
  always_comb begin
    xferA   = grant[0];
    xferB   = grant[1];
    a_ready = grant[0];
    b_ready = grant[1];
  end

  // Next-state logic: load on transfer, count down while dwelling, fall idle when starved
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    aOut_d     = aOut_q;
    bOut_d     = bOut_q;
    sel_d      = sel_q;
    outValid_d = outValid_q;
    if (xferA || xferB) begin
      if (xferA) begin
        aOut_d = a_in;
        sel_d  = SEL_A;
        last_d = SEL_A;
      end else begin
        bOut_d = b_in;
        sel_d  = SEL_B;
        last_d = SEL_B;
      end
      outValid_d = 1'b1;
      cnt_d      = RELOAD;
      state_d    = ST_DWELL;
    end else if (state_q == ST_DWELL) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d    = ST_IDLE;
        outValid_d = 1'b0;
      end
    end
  end

  // State registers; reset makes A win the first tie by pretending B was last granted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= SEL_B;
      aOut_q     <= '0;
      bOut_q     <= '0;
      sel_q      <= SEL_A;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      aOut_q     <= aOut_d;
      bOut_q     <= bOut_d;
      sel_q      <= sel_d;
      outValid_q <= outValid_d;
    end
  end

  // Registered presentation drives the mux directly
  always_comb begin
    a_out     = aOut_q;
    b_out     = bOut_q;
    s         = sel_q;
    out_valid = outValid_q;
  end

endmodule

// File: tb/tb_mux_4bit_rr_feeder.sv
// Self-checking bench for mux_4bit_rr_feeder: a cycle model predicts readies and
// outputs, and each accepted word is queued and compared when it is presented.
module tb_mux_4bit_rr_feeder;

  localparam int W     = 4;
  localparam int DWELL = 4;

  typedef struct {
    logic         ch;
    logic [W-1:0] data;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] aIn, bIn;
  logic         aValid, bValid;
  logic         aReady, bReady;
  logic [W-1:0] aOut, bOut;
  logic         sOut, outValid;

  logic         rst1;
  logic [W-1:0] a1In, b1In;
  logic         a1Valid, b1Valid;
  logic         a1Ready, b1Ready;
  logic [W-1:0] a1Out, b1Out;
  logic         s1, ov1;

  int checks = 0;
  int passes = 0;

  word_t sb[$];

  // Reference model state
  logic         mDwell;
  logic [7:0]   mCnt;
  logic         mLast;
  logic [W-1:0] mA, mB;
  logic         mS, mOv;

  always #5 clk = ~clk;

  mux_4bit_rr_feeder #(.WIDTH(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst),
    .a_in(aIn), .a_valid(aValid), .a_ready(aReady),
    .b_in(bIn), .b_valid(bValid), .b_ready(bReady),
    .a_out(aOut), .b_out(bOut), .s(sOut), .out_valid(outValid)
  );

  mux_4bit_rr_feeder #(.WIDTH(W), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst1),
    .a_in(a1In), .a_valid(a1Valid), .a_ready(a1Ready),
    .b_in(b1In), .b_valid(b1Valid), .b_ready(b1Ready),
    .a_out(a1Out), .b_out(b1Out), .s(s1), .out_valid(ov1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic av, input logic [W-1:0] ai,
                               input logic bv, input logic [W-1:0] bi);
    rst    = r;
    aValid = av;
    aIn    = ai;
    bValid = bv;
    bIn    = bi;
  endtask

  task automatic modelReset();
    mDwell = 1'b0;
    mCnt   = 8'd0;
    mLast  = 1'b1;
    mA     = '0;
    mB     = '0;
    mS     = 1'b0;
    mOv    = 1'b0;
  endtask

  // One clock of the main DUT: check at negedge, advance the model, cross the edge
  task automatic runCycle();
    logic  open, gA, gB;
    word_t w;
    @(negedge clk);
    open = !rst && (!mDwell || mCnt == 8'd0);
    gA   = open && aValid && (!bValid || mLast == 1'b1);
    gB   = open && bValid && (!aValid || mLast == 1'b0);
    checkOutput("a_ready", aReady, gA);
    checkOutput("b_ready", bReady, gB);
    checkOutput("out_valid", outValid, mOv);
    checkOutput("s", sOut, mS);
    checkOutput("a_out", aOut, mA);
    checkOutput("b_out", bOut, mB);
    if (sb.size() > 0) begin
      w = sb.pop_front();
      checkOutput("sb_sel", sOut, w.ch);
      checkOutput("sb_data", sOut ? bOut : aOut, w.data);
      checkOutput("sb_valid", outValid, 1'b1);
    end
    if (rst) begin
      modelReset();
    end else if (gA || gB) begin
      w.ch   = gB;
      w.data = gB ? bIn : aIn;
      sb.push_back(w);
      if (gA) mA = aIn;
      else    mB = bIn;
      mS     = gB;
      mLast  = gB;
      mOv    = 1'b1;
      mCnt   = 8'(DWELL - 1);
      mDwell = 1'b1;
    end else if (mDwell) begin
      if (mCnt != 8'd0) mCnt = mCnt - 8'd1;
      else begin
        mDwell = 1'b0;
        mOv    = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  initial begin
    modelReset();
    rst1    = 1'b1;
    a1Valid = 1'b1;
    b1Valid = 1'b1;
    a1In    = 4'h7;
    b1In    = 4'h8;

    // Reset with both sources valid: no readies, outputs at reset values
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 4'hF);
    @(posedge clk);
    #1;
    runCycles(2);

    // Single A word presented for DWELL cycles, then idle keeping a_out
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    runCycle();
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b0, 4'h0);
    runCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    runCycles(7);

    // Continuous contention alternates channels without a bubble
    applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, 4'hC);
    runCycles(17);
    applyStimulus(1'b0, 1'b0, 4'h3, 1'b0, 4'hC);
    runCycles(6);

    // b_in changes during B's dwell and must be ignored
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h5);
    runCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h9);
    runCycles(6);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h9);
    runCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h9);
    runCycles(6);

    // Reset pulse in the middle of a B presentation, then A wins the first tie
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'h6);
    runCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h6);
    runCycle();
    applyStimulus(1'b1, 1'b1, 4'h2, 1'b1, 4'h6);
    runCycle();
    applyStimulus(1'b0, 1'b1, 4'h2, 1'b1, 4'h6);
    runCycles(10);
    applyStimulus(1'b0, 1'b0, 4'h2, 1'b0, 4'h6);
    runCycles(5);

    // DWELL=1 instance: readies and select alternate every cycle
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("d1_a_ready", a1Ready, (i % 2) == 0);
      checkOutput("d1_b_ready", b1Ready, (i % 2) == 1);
      if (i > 0) begin
        checkOutput("d1_s", s1, (i % 2) == 0);
        checkOutput("d1_out_valid", ov1, 1'b1);
        checkOutput("d1_data", s1 ? b1Out : a1Out, s1 ? 4'h8 : 4'h7);
      end
      @(posedge clk);
      #1;
    end

    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
